// File: rtl/pe_seq_ctrl.sv
// Sequencer for one convolution PE: loads weights and samples from valid/ready streams,
// enables the PE until done (or timeout), then returns the captured partial sums.
module pe_seq_ctrl #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned INPUT_SIZE  = 8,
    parameter int unsigned WEIGHT_SIZE = 3,
    parameter int unsigned TIMEOUT     = 64,
    localparam int unsigned PSUM_W     = 2*DATA_WIDTH + 2,
    localparam int unsigned NUM_PSUM   = INPUT_SIZE - 2
) (
    input  logic                                         clk_i,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic                                         keep_w,
    input  logic                                         w_valid,
    output logic                                         w_ready,
    input  logic [DATA_WIDTH-1:0]                        w_data,
    input  logic                                         d_valid,
    output logic                                         d_ready,
    input  logic [DATA_WIDTH-1:0]                        d_data,
    output logic                                         pe_en,
    output logic [WEIGHT_SIZE-1:0][DATA_WIDTH-1:0]       pe_weight_o,
    output logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]        pe_data_o,
    input  logic [NUM_PSUM-1:0][PSUM_W-1:0]              pe_psum_i,
    input  logic                                         pe_done_i,
    output logic                                         m_valid,
    input  logic                                         m_ready,
    output logic [NUM_PSUM-1:0][PSUM_W-1:0]              m_psum,
    output logic                                         busy,
    output logic                                         err_timeout
);

    localparam int unsigned WC_W = $clog2(WEIGHT_SIZE + 1);
    localparam int unsigned DC_W = $clog2(INPUT_SIZE + 1);
    localparam int unsigned TC_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_D,
        RUN,
        DRAIN
    } state_t;

    state_t                                  state;
    state_t                                  state_next;
    logic [WC_W-1:0]                         w_cnt;
    logic [DC_W-1:0]                         d_cnt;
    logic [TC_W-1:0]                         tmo_cnt;
    logic                                    w_loaded;
    logic [WEIGHT_SIZE-1:0][DATA_WIDTH-1:0]  w_buf;
    logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]   d_buf;
    logic                                    w_fire;
    logic                                    d_fire;
    logic                                    w_last;
    logic                                    d_last;
    logic                                    done_hit;
    logic                                    tmo_hit;

    assign pe_weight_o = w_buf;
    assign pe_data_o   = d_buf;

    // State register
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; ready strobes are registered so the fire terms use their current value
    always_comb begin
        state_next = state;
        w_fire     = w_valid && w_ready;
        d_fire     = d_valid && d_ready;
        w_last     = (w_cnt == WC_W'(WEIGHT_SIZE - 1));
        d_last     = (d_cnt == DC_W'(INPUT_SIZE - 1));
        done_hit   = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (keep_w && w_loaded) ? LOAD_D : LOAD_W;
                end
            end
            LOAD_W: begin
                if (w_fire && w_last) begin
                    state_next = LOAD_D;
                end
            end
            LOAD_D: begin
                if (d_fire && d_last) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (pe_done_i) begin
                    done_hit   = 1'b1;
                    state_next = DRAIN;
                end else if (tmo_cnt == TC_W'(TIMEOUT - 1)) begin
                    tmo_hit    = 1'b1;
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (m_valid && m_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs, buffers and counters
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            w_ready     <= 1'b0;
            d_ready     <= 1'b0;
            pe_en       <= 1'b0;
            m_valid     <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            m_psum      <= '0;
            w_cnt       <= '0;
            d_cnt       <= '0;
            tmo_cnt     <= '0;
            w_loaded    <= 1'b0;
            w_buf       <= '0;
            d_buf       <= '0;
        end else begin
            w_ready     <= (state_next == LOAD_W);
            d_ready     <= (state_next == LOAD_D);
            pe_en       <= (state_next == RUN);
            m_valid     <= (state_next == DRAIN);
            busy        <= (state_next != IDLE);
            err_timeout <= tmo_hit;

            if (done_hit) begin
                m_psum <= pe_psum_i;
            end

            if (state != LOAD_W && state_next == LOAD_W) begin
                w_cnt <= '0;
            end else if (w_fire) begin
                w_cnt <= w_cnt + WC_W'(1);
            end
            for (int i = 0; i < int'(WEIGHT_SIZE); i++) begin
                if (w_fire && w_cnt == WC_W'(i)) begin
                    w_buf[i] <= w_data;
                end
            end
            if (w_fire && w_last) begin
                w_loaded <= 1'b1;
            end

            // Cleared on every LOAD_D entry, including the weight-reuse path from IDLE
            if (state != LOAD_D && state_next == LOAD_D) begin
                d_cnt <= '0;
            end else if (d_fire) begin
                d_cnt <= d_cnt + DC_W'(1);
            end
            for (int i = 0; i < int'(INPUT_SIZE); i++) begin
                if (d_fire && d_cnt == DC_W'(i)) begin
                    d_buf[i] <= d_data;
                end
            end

            if (state != RUN && state_next == RUN) begin
                tmo_cnt <= '0;
            end else if (state == RUN && !pe_done_i) begin
                tmo_cnt <= tmo_cnt + TC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Scoreboard bench for pe_seq_ctrl with a behavioural PE (done on its 4th enabled cycle).
module tb_pe_seq_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned IS = 8;
    localparam int unsigned WS = 3;
    localparam int unsigned PW = 2*DW + 2;
    localparam int unsigned NP = IS - 2;

    logic                  clk_i = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  keep_w = 1'b0;
    logic                  w_valid = 1'b0;
    logic                  w_ready;
    logic [DW-1:0]         w_data = '0;
    logic                  d_valid = 1'b0;
    logic                  d_ready;
    logic [DW-1:0]         d_data = '0;
    logic                  pe_en;
    logic [WS-1:0][DW-1:0] pe_weight_o;
    logic [IS-1:0][DW-1:0] pe_data_o;
    logic [NP-1:0][PW-1:0] pe_psum_i;
    logic                  pe_done_i;
    logic                  m_valid;
    logic                  m_ready = 1'b0;
    logic [NP-1:0][PW-1:0] m_psum;
    logic                  busy;
    logic                  err_timeout;

    pe_seq_ctrl dut (
        .clk_i(clk_i), .rst(rst), .start(start), .keep_w(keep_w),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data),
        .pe_en(pe_en), .pe_weight_o(pe_weight_o), .pe_data_o(pe_data_o),
        .pe_psum_i(pe_psum_i), .pe_done_i(pe_done_i),
        .m_valid(m_valid), .m_ready(m_ready), .m_psum(m_psum),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural PE
    int   pe_cnt = 0;
    logic pe_hang = 1'b0;
    logic done_pulse = 1'b0;
    always @(posedge clk_i) pe_cnt <= pe_en ? pe_cnt + 1 : 0;
    assign pe_done_i = (pe_en && pe_cnt == 3 && !pe_hang) || done_pulse;
    always_comb begin
        logic [PW-1:0] acc;
        pe_psum_i = '0;
        for (int k = 0; k < int'(NP); k++) begin
            acc = '0;
            for (int j = 0; j < int'(WS); j++) begin
                acc = acc + PW'(pe_data_o[k+j]) * PW'(pe_weight_o[j]);
            end
            pe_psum_i[k] = acc;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stimulus model and scoreboard
    logic [DW-1:0]         mw [WS];
    logic [DW-1:0]         md [IS];
    logic [NP*PW-1:0]      sb_q [$];
    logic [NP-1:0][PW-1:0] last_psum = '0;
    int results = 0;
    int pe_en_cycles = 0;
    int mvalid_cycles = 0;
    int tmo_pulses = 0;
    int w_ready_seen = 0;
    int ready_both = 0;

    function automatic logic [NP*PW-1:0] exp_psum();
        logic [NP-1:0][PW-1:0] r;
        for (int k = 0; k < int'(NP); k++) begin
            r[k] = '0;
            for (int j = 0; j < int'(WS); j++) r[k] = r[k] + PW'(md[k+j]) * PW'(mw[j]);
        end
        return r;
    endfunction

    function automatic logic [IS*DW-1:0] exp_data();
        logic [IS-1:0][DW-1:0] v;
        for (int i = 0; i < int'(IS); i++) v[i] = md[i];
        return v;
    endfunction

    function automatic logic [WS*DW-1:0] exp_weight();
        logic [WS-1:0][DW-1:0] v;
        for (int i = 0; i < int'(WS); i++) v[i] = mw[i];
        return v;
    endfunction

    // Result monitor, sampled mid-cycle
    always @(negedge clk_i) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                results++;
                last_psum = m_psum;
                if (sb_q.size() == 0) check("unexpected_result", 1'b1, 1'b0);
                else check("psum", m_psum, sb_q.pop_front());
            end
            if (pe_en) pe_en_cycles++;
            if (m_valid) mvalid_cycles++;
            if (err_timeout) tmo_pulses++;
            if (w_ready) w_ready_seen++;
            if (w_ready && d_ready) ready_both++;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic k);
        start = 1'b1;
        keep_w = k;
        tick();
        start = 1'b0;
        keep_w = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] v, input int gap);
        int n = 0;
        repeat ($urandom_range(0, gap)) tick();
        w_valid = 1'b1;
        w_data = v;
        while (!w_ready && n < 100) begin tick(); n++; end
        if (!w_ready) check("w_ready_wait", 1'b0, 1'b1);
        tick();
        w_valid = 1'b0;
    endtask

    task automatic send_d(input logic [DW-1:0] v, input int gap);
        int n = 0;
        repeat ($urandom_range(0, gap)) tick();
        d_valid = 1'b1;
        d_data = v;
        while (!d_ready && n < 100) begin tick(); n++; end
        if (!d_ready) check("d_ready_wait", 1'b0, 1'b1);
        tick();
        d_valid = 1'b0;
    endtask

    task automatic load(input logic k, input int gap);
        if (!k) for (int i = 0; i < int'(WS); i++) send_w(mw[i], gap);
        for (int i = 0; i < int'(IS); i++) send_d(md[i], gap);
    endtask

    task automatic wait_result(input int target);
        int n = 0;
        while (results < target && n < 300) begin tick(); n++; end
        if (results < target) check("result_wait", 1'b0, 1'b1);
    endtask

    initial begin
        int r0;
        int n;
        int held_bad;
        logic [NP-1:0][PW-1:0] held;

        repeat (2) tick();
        // Reset values
        check("rst_busy", busy, 1'b0);
        check("rst_ready", {w_ready, d_ready}, 2'b00);
        check("rst_pe_en", pe_en, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_err", err_timeout, 1'b0);
        check("rst_m_psum", m_psum, '0);
        check("rst_bufs", {pe_data_o, pe_weight_o}, '0);
        rst = 1'b0;
        tick();

        // 1: basic job
        mw = '{8'd1, 8'd2, 8'd3};
        for (int i = 0; i < int'(IS); i++) md[i] = DW'(i + 1);
        m_ready = 1'b1;
        pe_en_cycles = 0; mvalid_cycles = 0; r0 = results;
        do_start(1'b0);
        check("w_ready_latency", w_ready, 1'b1);
        load(1'b0, 0);
        sb_q.push_back(exp_psum());
        check("t1_data_buf", pe_data_o, exp_data());
        check("t1_weight_buf", pe_weight_o, exp_weight());
        wait_result(r0 + 1);
        check("t1_busy_fall", busy, 1'b0);
        check("t1_psum0", last_psum[0], PW'(14));
        check("t1_psum5", last_psum[5], PW'(44));
        check("t1_pe_en_cycles", pe_en_cycles, 4);
        check("t1_m_valid_cycles", mvalid_cycles, 1);

        // 2: weight reuse
        for (int i = 0; i < int'(IS); i++) md[i] = DW'(IS - i);
        w_ready_seen = 0; r0 = results;
        do_start(1'b1);
        load(1'b1, 0);
        sb_q.push_back(exp_psum());
        wait_result(r0 + 1);
        check("t2_no_w_ready", w_ready_seen, 0);
        check("t2_psum0", last_psum[0], PW'(40));

        // 3: stalls and result backpressure
        for (int i = 0; i < int'(IS); i++) md[i] = DW'(i + 1);
        m_ready = 1'b0; r0 = results;
        do_start(1'b0);
        load(1'b0, 3);
        sb_q.push_back(exp_psum());
        check("t3_data_buf", pe_data_o, exp_data());
        check("t3_weight_buf", pe_weight_o, exp_weight());
        n = 0;
        while (!m_valid && n < 100) begin tick(); n++; end
        check("t3_m_valid_up", m_valid, 1'b1);
        held = m_psum; held_bad = 0;
        repeat (10) begin
            tick();
            if (!m_valid || m_psum !== held) held_bad++;
        end
        check("t3_hold", held_bad, 0);
        m_ready = 1'b1;
        wait_result(r0 + 1);
        check("t3_psum0", last_psum[0], PW'(14));

        // 4: timeout
        pe_hang = 1'b1;
        pe_en_cycles = 0; mvalid_cycles = 0; tmo_pulses = 0;
        do_start(1'b1);
        load(1'b1, 0);
        n = 0;
        while (!err_timeout && n < 200) begin tick(); n++; end
        check("t4_err_seen", err_timeout, 1'b1);
        check("t4_run_cycles", pe_en_cycles, 64);
        check("t4_idle", {busy, pe_en}, 2'b00);
        tick();
        check("t4_err_one_cycle", err_timeout, 1'b0);
        check("t4_pulses", tmo_pulses, 1);
        check("t4_no_m_valid", mvalid_cycles, 0);
        pe_hang = 1'b0; r0 = results;
        do_start(1'b1);
        load(1'b1, 0);
        sb_q.push_back(exp_psum());
        wait_result(r0 + 1);

        // 5: reset during LOAD_D
        do_start(1'b1);
        for (int i = 0; i < 4; i++) send_d(md[i], 0);
        rst = 1'b1;
        #1;
        check("t5_outputs", {busy, w_ready, d_ready, pe_en, m_valid, err_timeout}, 6'b0);
        check("t5_bufs", {pe_data_o, pe_weight_o}, '0);
        tick();
        rst = 1'b0;
        tick();
        r0 = results;
        do_start(1'b1);
        check("t5_reload_w", w_ready, 1'b1);
        load(1'b0, 0);
        sb_q.push_back(exp_psum());
        wait_result(r0 + 1);

        // 6: ignored start in RUN and done in LOAD_D
        w_ready_seen = 0; r0 = results;
        do_start(1'b1);
        for (int i = 0; i < 4; i++) send_d(md[i], 0);
        done_pulse = 1'b1;
        tick();
        done_pulse = 1'b0;
        check("t6_still_load_d", d_ready, 1'b1);
        for (int i = 4; i < int'(IS); i++) send_d(md[i], 0);
        sb_q.push_back(exp_psum());
        check("t6_in_run", pe_en, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        check("t6_one_result", results - r0, 1);
        check("t6_no_restart", w_ready_seen, 0);
        check("t6_idle", busy, 1'b0);

        check("sb_empty", sb_q.size(), 0);
        check("ready_exclusive", ready_both, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
